// File: rtl/mp_addsub_serial.sv
// Block-serial N-bit add/sub: one BLOCK-bit slice per cycle, LSB first, result after NB cycles.
// in_ready only in IDLE or in DONE while out_ready; results held stable under out_ready=0.
module mp_addsub_serial #(
    parameter int N     = 4096,
    parameter int BLOCK = 128
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] op_a,
    input  logic [N-1:0] op_b,
    input  logic         mode,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         ovf
);
    localparam int NB = N / BLOCK;
    localparam int KW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [KW-1:0] r_k;
    logic          r_c;
    logic          r_mode;
    logic          r_sa;
    logic          r_sb;
    logic [N-1:0]  r_a;
    logic [N-1:0]  r_b;
    logic [N-1:0]  r_sum;
    logic          r_cout;
    logic          r_ovf;

    logic             w_accept;
    logic             w_last;
    logic [BLOCK:0]   w_t;
    logic             w_ovf;

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = (r_state == S_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_k == KW'(NB - 1));
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;

    // Operands are shifted down one slice per cycle, so the active slice is always the low BLOCK bits.
    always_comb begin
        w_t = '0;
        if (r_mode)
            w_t = {1'b0, r_a[BLOCK-1:0]} + {1'b0, r_b[BLOCK-1:0]} + {{BLOCK{1'b0}}, r_c};
        else
            w_t = {1'b0, r_a[BLOCK-1:0]} - {1'b0, r_b[BLOCK-1:0]} - {{BLOCK{1'b0}}, r_c};
    end

    // Operand sign bits are latched at accept because the shifted copies lose them.
    assign w_ovf = r_mode ? ((r_sa == r_sb) && (w_t[BLOCK-1] != r_sa))
                          : ((r_sa != r_sb) && (w_t[BLOCK-1] != r_sa));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_k     <= '0;
            r_c     <= 1'b0;
            r_mode  <= 1'b0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_RUN;
            r_k     <= '0;
            r_c     <= cin;
            r_mode  <= mode;
            r_sa    <= op_a[N-1];
            r_sb    <= op_b[N-1];
            r_a     <= op_a;
            r_b     <= op_b;
        end else if (r_state == S_RUN) begin
            r_sum[r_k*BLOCK +: BLOCK] <= w_t[BLOCK-1:0];
            r_c <= w_t[BLOCK];
            r_a <= r_a >> BLOCK;
            r_b <= r_b >> BLOCK;
            if (w_last) begin
                r_cout  <= w_t[BLOCK];
                r_ovf   <= w_ovf;
                r_k     <= '0;
                r_state <= S_DONE;
            end else begin
                r_k <= r_k + 1'b1;
            end
        end else if ((r_state == S_DONE) && out_ready) begin
            r_state <= S_IDLE;
        end else if ((r_state != S_IDLE) && (r_state != S_DONE)) begin
            r_state <= S_IDLE;
        end
    end
endmodule

// File: tb/tb_mp_addsub_serial.sv
// Bench: directed cases on a 256/64 instance, randomized reference-model run on a 4096/128 instance.
module tb_mp_addsub_serial;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Small instance
    logic         s_in_valid, s_in_ready, s_mode, s_cin, s_out_valid, s_out_ready, s_cout, s_ovf;
    logic [255:0] s_op_a, s_op_b, s_sum;
    // Default-size instance
    logic          l_in_valid, l_in_ready, l_mode, l_cin, l_out_valid, l_out_ready, l_cout, l_ovf;
    logic [4095:0] l_op_a, l_op_b, l_sum;

    mp_addsub_serial #(.N(256), .BLOCK(64)) dut_s (
        .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
        .op_a(s_op_a), .op_b(s_op_b), .mode(s_mode), .cin(s_cin),
        .out_valid(s_out_valid), .out_ready(s_out_ready),
        .sum(s_sum), .cout(s_cout), .ovf(s_ovf)
    );

    mp_addsub_serial dut_l (
        .clk(clk), .rst_n(rst_n), .in_valid(l_in_valid), .in_ready(l_in_ready),
        .op_a(l_op_a), .op_b(l_op_b), .mode(l_mode), .cin(l_cin),
        .out_valid(l_out_valid), .out_ready(l_out_ready),
        .sum(l_sum), .cout(l_cout), .ovf(l_ovf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [4096:0] obs, input logic [4096:0] exp);
        int d;
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            d = -1;
            for (int i = 0; i < 4097; i++)
                if (d < 0 && obs[i] !== exp[i]) d = i;
            $display("FAIL %s: got %h expected %h (low 128 bits), first differing bit %0d",
                     tag, obs[127:0], exp[127:0], d);
        end
    endtask

    // Reference: exact integer arithmetic in 4098 bits; overflow = signed result outside N-bit range.
    function automatic void ref_op(input logic [4095:0] a, input logic [4095:0] b,
                                   input logic m, input logic c,
                                   output logic [4095:0] s, output logic co, output logic ov);
        logic [4097:0] ua, ub, cc, r, sa, sb, sr, bias, one;
        one  = 4098'(1);
        ua   = {2'b00, a};
        ub   = {2'b00, b};
        cc   = {4097'b0, c};
        r    = m ? (ua + ub + cc) : (ua - ub - cc);
        s    = r[4095:0];
        co   = r[4096];
        sa   = a[4095] ? (ua - (one << 4096)) : ua;
        sb   = b[4095] ? (ub - (one << 4096)) : ub;
        sr   = m ? (sa + sb + cc) : (sa - sb - cc);
        bias = sr + (one << 4095);
        ov   = (bias >= (one << 4096));
    endfunction

    function automatic logic [4095:0] rand4096();
        logic [4095:0] v;
        for (int i = 0; i < 128; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic s_wait_result(input string tag, output int lat);
        lat = 0;
        while (!s_out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 4097'(lat), 4097'(4));
    endtask

    task automatic s_op(input logic [255:0] a, input logic [255:0] b, input logic m, input logic c,
                        input logic [255:0] es, input logic ec, input logic eo, input string tag);
        int lat;
        @(negedge clk);
        s_op_a = a; s_op_b = b; s_mode = m; s_cin = c;
        s_in_valid = 1'b1; s_out_ready = 1'b1;
        #1 check({tag, "_rdy"}, 4097'(s_in_ready), 4097'(1));
        @(negedge clk);
        s_in_valid = 1'b0;
        s_wait_result(tag, lat);
        check({tag, "_sum"},  {3841'b0, s_sum}, {3841'b0, es});
        check({tag, "_cout"}, 4097'(s_cout), 4097'(ec));
        check({tag, "_ovf"},  4097'(s_ovf),  4097'(eo));
        @(negedge clk);
        check({tag, "_vld_drop"}, 4097'(s_out_valid), 4097'(0));
    endtask

    initial begin
        logic [255:0]  all1, maxpos, minneg;
        logic [255:0]  held;
        logic [4095:0] a, b, e_sum, p_sum;
        logic          m, c, e_cout, e_ovf, p_cout, p_ovf;
        int            lat, g;
        bit            spurious;

        all1   = '1;
        maxpos = {1'b0, {255{1'b1}}};
        minneg = {1'b1, 255'b0};
        p_sum  = '0; p_cout = 1'b0; p_ovf = 1'b0;

        rst_n = 1'b0;
        s_in_valid = 0; s_out_ready = 0; s_mode = 0; s_cin = 0; s_op_a = '0; s_op_b = '0;
        l_in_valid = 0; l_out_ready = 0; l_mode = 0; l_cin = 0; l_op_a = '0; l_op_b = '0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready",  4097'(s_in_ready),  4097'(1));
        check("rst_out_valid", 4097'(s_out_valid), 4097'(0));
        check("rst_sum",       {3841'b0, s_sum},   4097'(0));
        check("rst_cout_ovf",  4097'({s_cout, s_ovf}), 4097'(0));
        check("rst_l_vld_rdy", 4097'({l_out_valid, l_in_ready}), 4097'(1));
        rst_n = 1'b1;

        s_op(all1, 256'd1, 1'b1, 1'b0, 256'd0, 1'b1, 1'b0, "add_wrap");
        s_op(256'd0, 256'd1, 1'b0, 1'b0, all1, 1'b1, 1'b0, "sub_borrow");
        s_op(256'd5, 256'd3, 1'b0, 1'b1, 256'd1, 1'b0, 1'b0, "sub_bin");
        s_op({192'b0, {64{1'b1}}}, 256'd1, 1'b1, 1'b0, {191'b0, 1'b1, 64'b0}, 1'b0, 1'b0, "slice_carry");
        s_op(maxpos, 256'd1, 1'b1, 1'b0, minneg, 1'b0, 1'b1, "add_ovf");
        s_op(minneg, 256'd1, 1'b0, 1'b0, maxpos, 1'b0, 1'b1, "sub_ovf");

        // Back-pressure: hold result for 10 cycles while a second op waits.
        @(negedge clk);
        s_op_a = 256'd123456789; s_op_b = 256'd987654321; s_mode = 1'b1; s_cin = 1'b0;
        s_in_valid = 1'b1; s_out_ready = 1'b0;
        @(negedge clk);
        s_in_valid = 1'b0;
        s_wait_result("bp1", lat);
        check("bp1_sum", {3841'b0, s_sum}, 4097'(1111111110));
        held = s_sum;
        s_op_a = 256'd1000; s_op_b = 256'd1; s_mode = 1'b0; s_cin = 1'b0; s_in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_sum", {3841'b0, s_sum}, {3841'b0, held});
            check("bp_hold_flags", 4097'({s_out_valid, s_in_ready, s_cout, s_ovf}), 4097'(4'b1000));
        end
        s_out_ready = 1'b1;
        #1 check("bp_rdy_follow", 4097'(s_in_ready), 4097'(1));
        @(negedge clk);
        s_in_valid = 1'b0;
        check("bp2_run", 4097'({s_out_valid, s_in_ready}), 4097'(0));
        s_wait_result("bp2", lat);
        check("bp2_sum", {3841'b0, s_sum}, 4097'(999));
        check("bp2_flags", 4097'({s_cout, s_ovf}), 4097'(0));

        // Reset in the middle of a run (during slice k=2).
        @(negedge clk);
        s_op_a = all1; s_op_b = 256'd1; s_mode = 1'b1; s_cin = 1'b0; s_in_valid = 1'b1;
        @(negedge clk);
        s_in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_rdy_vld", 4097'({s_in_ready, s_out_valid}), 4097'(2'b10));
        check("mrst_sum", {3841'b0, s_sum}, 4097'(0));
        check("mrst_flags", 4097'({s_cout, s_ovf}), 4097'(0));
        @(negedge clk);
        rst_n = 1'b1;
        spurious = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (s_out_valid) spurious = 1'b1;
        end
        check("mrst_no_vld", 4097'(spurious), 4097'(0));
        s_op(256'd10, 256'd20, 1'b1, 1'b0, 256'd30, 1'b0, 1'b0, "post_rst");

        // Randomized run on the default-size instance.
        for (int i = 0; i < 1000; i++) begin
            a = rand4096(); b = rand4096();
            m = 1'($urandom_range(0, 1)); c = 1'($urandom_range(0, 1));
            if (i % 10 == 3) a = b;
            ref_op(a, b, m, c, e_sum, e_cout, e_ovf);
            if ($urandom_range(0, 3) == 0) begin
                @(negedge clk);
                l_out_ready = 1'b1;
            end
            @(negedge clk);
            l_op_a = a; l_op_b = b; l_mode = m; l_cin = c;
            l_in_valid = 1'b1; l_out_ready = 1'($urandom_range(0, 1));
            g = 0;
            #1;
            while (!l_in_ready && g < 400) begin
                @(negedge clk);
                l_out_ready = 1'($urandom_range(0, 1));
                g++;
                #1;
            end
            check("rnd_accept", 4097'(l_in_ready), 4097'(1));
            if (l_out_valid) begin
                check("rnd_hold_sum", {1'b0, l_sum}, {1'b0, p_sum});
                check("rnd_hold_flags", 4097'({l_cout, l_ovf}), 4097'({p_cout, p_ovf}));
            end
            @(negedge clk);
            l_out_ready = 1'b0;
            g = 0;
            while (!l_out_valid && g < 100) begin
                l_in_valid = 1'($urandom_range(0, 1));
                l_op_a = rand4096(); l_mode = ~m; l_cin = ~c;
                @(negedge clk);
                g++;
            end
            l_in_valid = 1'b0;
            check("rnd_lat", 4097'(g), 4097'(32));
            check("rnd_sum", {1'b0, l_sum}, {1'b0, e_sum});
            check("rnd_cout", 4097'(l_cout), 4097'(e_cout));
            check("rnd_ovf", 4097'(l_ovf), 4097'(e_ovf));
            p_sum = e_sum; p_cout = e_cout; p_ovf = e_ovf;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
